// File: rtl/buyruk_sirala.sv
// Issuer for the packed ALU instruction interface: queues (islem, v1, v2) requests,
// sends one packed word at a time to the ALU and hands the captured result downstream.
module buyruk_sirala #(
   parameter int UZUNLUK  = 8,
   parameter int DERINLIK = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   giris_gecerli,
   output logic                   giris_hazir,
   input  logic [2:0]             islem,
   input  logic [UZUNLUK/2-1:0]   v1,
   input  logic [UZUNLUK/2-1:0]   v2,
   output logic [UZUNLUK+2:0]     buyruk,
   input  logic [UZUNLUK/2:0]     alu_sonuc,
   output logic                   cikis_gecerli,
   input  logic                   cikis_hazir,
   output logic [UZUNLUK/2:0]     sonuc,
   output logic [7:0]             sayac,
   output logic                   hata
);

   localparam int AW = $clog2(DERINLIK);
   localparam logic [AW:0] TAM = DERINLIK[AW:0];

   localparam logic [1:0] BOS    = 2'd0;
   localparam logic [1:0] GONDER = 2'd1;
   localparam logic [1:0] SONUC  = 2'd2;

   logic [UZUNLUK+2:0] mem [DERINLIK];
   logic [AW-1:0]      yaz_ptr;
   logic [AW-1:0]      oku_ptr;
   logic [AW:0]        adet;
   logic [1:0]         durum;
   logic               push;
   logic               pop;
   logic               bos;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
   assign giris_hazir = (adet != TAM);
   assign bos         = (adet == '0);
   assign push        = giris_gecerli && giris_hazir;

   always_comb begin
      // NOTE: default first so every path assigns pop and no latch is inferred.
      pop = 1'b0;
      case (durum)
         BOS:     pop = !bos;
         SONUC:   pop = cikis_hazir && !bos;
         default: pop = 1'b0;
      endcase
   end

   // NOTE: storage is deliberately not reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[yaz_ptr] <= {islem, v1, v2};
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
         adet    <= '0;
      end else begin
         if (push) yaz_ptr <= yaz_ptr + AW'(1);
         if (pop)  oku_ptr <= oku_ptr + AW'(1);
         case ({push, pop})
            2'b10:   adet <= adet + (AW+1)'(1);
            2'b01:   adet <= adet - (AW+1)'(1);
            default: adet <= adet;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hata <= 1'b0;
      end else if (push && (islem > 3'b100)) begin
         hata <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         durum         <= BOS;
         buyruk        <= '0;
         sonuc         <= '0;
         cikis_gecerli <= 1'b0;
         sayac         <= '0;
      end else begin
         case (durum)
            BOS: begin
               if (pop) begin
                  buyruk <= mem[oku_ptr];
                  durum  <= GONDER;
               end
            end
            GONDER: begin
               // The ALU has had the whole cycle to settle on buyruk.
               sonuc         <= alu_sonuc;
               cikis_gecerli <= 1'b1;
               durum         <= SONUC;
            end
            SONUC: begin
               if (cikis_hazir) begin
                  cikis_gecerli <= 1'b0;
                  sayac         <= sayac + 8'd1;
                  if (pop) begin
                     buyruk <= mem[oku_ptr];
                     durum  <= GONDER;
                  end else begin
                     durum <= BOS;
                  end
               end
            end
            default: durum <= BOS;
         endcase
      end
   end

endmodule

// File: tb/tb_buyruk_sirala.sv
// Bench for buyruk_sirala: a result queue filled at push time from the opcode rules
// is compared against every presented result, plus directed literal expectations.
module tb_buyruk_sirala;

   localparam int UZUNLUK  = 8;
   localparam int DERINLIK = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        giris_gecerli = 1'b0;
   logic        giris_hazir;
   logic [2:0]  islem = '0;
   logic [3:0]  v1 = '0;
   logic [3:0]  v2 = '0;
   logic [10:0] buyruk;
   logic [4:0]  alu_sonuc;
   logic        cikis_gecerli;
   logic        cikis_hazir = 1'b1;
   logic [4:0]  sonuc;
   logic [7:0]  sayac;
   logic        hata;

   int          checks = 0;
   int          errors = 0;
   logic        izle = 1'b0;
   logic [4:0]  exp_q[$];
   logic [7:0]  model_cnt = '0;
   logic        model_hata = 1'b0;

   always #5 clk = ~clk;

   buyruk_sirala #(.UZUNLUK(UZUNLUK), .DERINLIK(DERINLIK)) dut (
      .clk(clk), .rst_n(rst_n),
      .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
      .islem(islem), .v1(v1), .v2(v2),
      .buyruk(buyruk), .alu_sonuc(alu_sonuc),
      .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir),
      .sonuc(sonuc), .sayac(sayac), .hata(hata)
   );

   function automatic logic [4:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd1:    return 5'(a) - 5'(b);
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         default: return 5'(a) + 5'(b);
      endcase
   endfunction

   // The ALU stand-in reads only the packed word, so packing errors show up as wrong results.
   assign alu_sonuc = alu(buyruk[10:8], buyruk[7:4], buyruk[3:0]);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && izle) begin
         check("sayac", 32'(sayac), 32'(model_cnt));
         check("hata", 32'(hata), 32'(model_hata));
         if (cikis_gecerli) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 32'(cikis_gecerli), 32'(0));
            end else begin
               check("sonuc", 32'(sonuc), 32'(exp_q[0]));
               if (cikis_hazir) begin
                  void'(exp_q.pop_front());
                  model_cnt = model_cnt + 8'd1;
               end
            end
         end
         if (giris_gecerli && giris_hazir) begin
            exp_q.push_back(alu(islem, v1, v2));
            if (islem > 3'd4) model_hata = 1'b1;
         end
      end
   end

   // Called at posedge+1 with the block idle and cikis_hazir high.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [10:0] word, input logic [4:0] lit);
      giris_gecerli = 1'b1; islem = op; v1 = a; v2 = b;
      @(posedge clk); #1 giris_gecerli = 1'b0;
      @(posedge clk); #1;
      check({nm, "_buyruk"}, 32'(buyruk), 32'(word));
      check({nm, "_valid_early"}, 32'(cikis_gecerli), 32'(0));
      @(posedge clk); #1;
      check({nm, "_valid"}, 32'(cikis_gecerli), 32'(1));
      check({nm, "_sonuc"}, 32'(sonuc), 32'(lit));
      @(posedge clk); #1;
      check({nm, "_valid_done"}, 32'(cikis_gecerli), 32'(0));
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || cikis_gecerli) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_drained"}, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      int acc;
      #2;
      check("rst_buyruk", 32'(buyruk), 32'(0));
      check("rst_sonuc", 32'(sonuc), 32'(0));
      check("rst_valid", 32'(cikis_gecerli), 32'(0));
      check("rst_sayac", 32'(sayac), 32'(0));
      check("rst_hata", 32'(hata), 32'(0));
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_hazir", 32'(giris_hazir), 32'(1));
      izle = 1'b1;

      run_op("add", 3'd0, 4'd5, 4'd3, 11'h053, 5'd8);
      check("add_sayac", 32'(sayac), 32'(1));
      run_op("sub", 3'd1, 4'd3, 4'd5, 11'h135, 5'h1E);
      run_op("xor", 3'd4, 4'hF, 4'hA, 11'h4FA, 5'h05);
      run_op("and", 3'd2, 4'hC, 4'hA, 11'h2CA, 5'h08);

      // Backpressure: one in flight plus a full queue.
      cikis_hazir = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         giris_gecerli = 1'b1; islem = 3'(i % 5); v1 = 4'(i + 1); v2 = 4'(2 * i);
         @(negedge clk);
         if (giris_hazir) acc++;
         @(posedge clk); #1;
      end
      giris_gecerli = 1'b0;
      check("bp_accepted", 32'(acc), 32'(5));
      check("bp_hazir_low", 32'(giris_hazir), 32'(0));
      cikis_hazir = 1'b1;
      drain("bp");
      check("bp_sayac", 32'(sayac), 32'(9));
      check("bp_hazir_back", 32'(giris_hazir), 32'(1));

      run_op("illegal", 3'd7, 4'd2, 4'd3, 11'h723, 5'd5);
      check("illegal_hata", 32'(hata), 32'(1));
      run_op("after_illegal", 3'd0, 4'd1, 4'd1, 11'h011, 5'd2);
      check("hata_sticky", 32'(hata), 32'(1));
      check("illegal_sayac", 32'(sayac), 32'(11));

      // Reset while a result is held and two entries are queued.
      cikis_hazir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         giris_gecerli = 1'b1; islem = 3'd3; v1 = 4'(i); v2 = 4'd8;
         @(posedge clk); #1;
      end
      giris_gecerli = 1'b0;
      check("mid_valid", 32'(cikis_gecerli), 32'(1));
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_buyruk", 32'(buyruk), 32'(0));
      check("mid_rst_sonuc", 32'(sonuc), 32'(0));
      check("mid_rst_valid", 32'(cikis_gecerli), 32'(0));
      check("mid_rst_sayac", 32'(sayac), 32'(0));
      check("mid_rst_hata", 32'(hata), 32'(0));
      exp_q.delete();
      model_cnt = '0;
      model_hata = 1'b0;
      #1 rst_n = 1'b1;
      cikis_hazir = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_valid", 32'(cikis_gecerli), 32'(0));
      check("post_rst_sayac", 32'(sayac), 32'(0));

      // 300 streamed operations wrap both pointers and the 8-bit counter.
      acc = 0;
      for (int n = 0; n < 2000 && acc < 300; n++) begin
         giris_gecerli = 1'b1;
         islem = 3'($urandom_range(0, 4));
         v1 = 4'($urandom_range(0, 15));
         v2 = 4'($urandom_range(0, 15));
         @(negedge clk);
         if (giris_hazir) acc++;
         @(posedge clk); #1;
      end
      giris_gecerli = 1'b0;
      check("wrap_accepted", 32'(acc), 32'(300));
      drain("wrap");
      check("wrap_sayac", 32'(sayac), 32'(44));

      izle = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
